// File: rtl/multi_channel_timer_if.sv
// Control and status bundle for multi_channel_timer.
// Every control input is level-sampled on each clk_in rising edge, with no valid/ready handshake; status outputs are registered, except irq.
interface multi_channel_timer_if #(
    parameter int WIDTH      = 16,
    parameter int NCH        = 4,
    parameter int PRESCALE_W = 8
);
    logic [PRESCALE_W-1:0] prescale;
    logic [NCH-1:0]        ch_start;
    logic [NCH-1:0]        ch_stop;
    logic [NCH-1:0]        ch_periodic;
    logic [NCH*WIDTH-1:0]  ch_reload;
    logic [NCH-1:0]        irq_clear;
    logic [NCH-1:0]        ch_running;
    logic [NCH-1:0]        ch_timeout;
    logic [NCH*WIDTH-1:0]  ch_count;
    logic [NCH-1:0]        irq_flags;
    logic                  irq;

    modport master (
        output prescale, ch_start, ch_stop, ch_periodic, ch_reload, irq_clear,
        input  ch_running, ch_timeout, ch_count, irq_flags, irq
    );

    modport slave (
        input  prescale, ch_start, ch_stop, ch_periodic, ch_reload, irq_clear,
        output ch_running, ch_timeout, ch_count, irq_flags, irq
    );
endinterface

// File: rtl/multi_channel_timer.sv
// NCH independent down-counting timers sharing one free-running prescaler,
// with one-shot/periodic modes, abort, count readback and sticky IRQ flags.
module multi_channel_timer #(
    parameter int WIDTH      = 16,
    parameter int NCH        = 4,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk_in,
    input  logic                  resetb,
    multi_channel_timer_if.slave  bus
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    logic [PRESCALE_W-1:0] pre_cnt;
    logic                  tick;

    state_t           state_q [NCH];
    state_t           state_d [NCH];
    logic [WIDTH-1:0] count_q [NCH];
    logic [WIDTH-1:0] count_d [NCH];
    logic [NCH-1:0]   mode_q, mode_d;
    logic [NCH-1:0]   tmo_q, tmo_d;
    logic [NCH-1:0]   flag_q, flag_d;

    // ">=" so that lowering prescale below the current pre_cnt ticks next cycle
    assign tick = (pre_cnt >= bus.prescale);

    always_ff @(posedge clk_in) begin
        if (!resetb) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!resetb) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= IDLE;
                count_q[i] <= '0;
            end
            mode_q <= '0;
            tmo_q  <= '0;
            flag_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                count_q[i] <= count_d[i];
            end
            mode_q <= mode_d;
            tmo_q  <= tmo_d;
            flag_q <= flag_d;
        end
    end

    // Priority per channel: stop > start > tick. An expiry sets the flag even
    // when irq_clear is asserted in the same cycle.
    always_comb begin
        mode_d = mode_q;
        tmo_d  = '0;
        flag_d = flag_q & ~bus.irq_clear;
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            count_d[i] = count_q[i];
            if (bus.ch_stop[i]) begin
                state_d[i] = IDLE;
                count_d[i] = '0;
            end else if (bus.ch_start[i]) begin
                state_d[i] = RUN;
                count_d[i] = bus.ch_reload[i*WIDTH +: WIDTH];
                mode_d[i]  = bus.ch_periodic[i];
            end else if (state_q[i] == RUN && tick) begin
                if (count_q[i] != '0) begin
                    count_d[i] = count_q[i] - WIDTH'(1);
                end else begin
                    tmo_d[i]  = 1'b1;
                    flag_d[i] = 1'b1;
                    if (mode_q[i]) begin
                        count_d[i] = bus.ch_reload[i*WIDTH +: WIDTH];
                    end else begin
                        state_d[i] = IDLE;
                    end
                end
            end
        end
    end

    // ch_running is the per-channel FSM state vector.
    always_comb begin
        bus.ch_count   = '0;
        bus.ch_running = '0;
        for (int i = 0; i < NCH; i++) begin
            bus.ch_count[i*WIDTH +: WIDTH] = count_q[i];
            bus.ch_running[i]              = (state_q[i] == RUN);
        end
        bus.ch_timeout = tmo_q;
        bus.irq_flags  = flag_q;
        bus.irq        = |flag_q;
    end

endmodule

// File: tb/tb_multi_channel_timer.sv
// Directed bench for multi_channel_timer: inputs are driven and outputs are
// checked on the falling clock edge, with hand-computed expected values.
module tb_multi_channel_timer;

  localparam int W   = 16;
  localparam int NCH = 4;
  localparam int PW  = 8;

  logic clk_in = 1'b0;
  logic resetb;
  int   n_vec = 0;
  int   n_err = 0;
  logic found;

  multi_channel_timer_if #(.WIDTH(W), .NCH(NCH), .PRESCALE_W(PW)) bus ();

  multi_channel_timer #(.WIDTH(W), .NCH(NCH), .PRESCALE_W(PW)) dut (
    .clk_in (clk_in),
    .resetb (resetb),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(negedge clk_in);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] cnt(input int ch);
    return bus.ch_count[ch*W +: W];
  endfunction

  initial begin
    resetb          = 1'b0;
    bus.prescale    = '0;
    bus.ch_start    = '0;
    bus.ch_stop     = '0;
    bus.ch_periodic = '0;
    bus.ch_reload   = '0;
    bus.irq_clear   = '0;
    repeat (3) step();
    check("rst_running", 64'(bus.ch_running), 64'h0);
    check("rst_timeout", 64'(bus.ch_timeout), 64'h0);
    check("rst_count",   64'(bus.ch_count),   64'h0);
    check("rst_flags",   64'(bus.irq_flags),  64'h0);
    check("rst_irq",     64'(bus.irq),        64'h0);
    resetb = 1'b1;
    step();

    // 1) one-shot, reload 5, prescale 0
    bus.ch_reload[0*W +: W] = 16'd5;
    bus.ch_start[0] = 1'b1;
    step();
    bus.ch_start[0] = 1'b0;
    check("t1_count5", 64'(cnt(0)), 64'd5);
    check("t1_run",    64'(bus.ch_running[0]), 64'd1);
    for (int k = 4; k >= 0; k--) begin
      step();
      check("t1_count", 64'(cnt(0)), 64'(k));
      check("t1_notmo", 64'(bus.ch_timeout[0]), 64'd0);
    end
    step();
    check("t1_tmo",    64'(bus.ch_timeout[0]), 64'd1);
    check("t1_idle",   64'(bus.ch_running[0]), 64'd0);
    check("t1_flag",   64'(bus.irq_flags), 64'h1);
    check("t1_irq",    64'(bus.irq), 64'd1);
    step();
    check("t1_tmo_end", 64'(bus.ch_timeout[0]), 64'd0);
    check("t1_cnt_end", 64'(cnt(0)), 64'd0);
    bus.irq_clear[0] = 1'b1;
    step();
    bus.irq_clear[0] = 1'b0;
    check("t1_clr", 64'(bus.irq_flags), 64'h0);

    // 2) periodic, reload 2, prescale 3 -> period 12
    bus.prescale = 8'd3;
    bus.ch_reload[1*W +: W] = 16'd2;
    bus.ch_periodic[1] = 1'b1;
    bus.ch_start[1] = 1'b1;
    step();
    bus.ch_start[1] = 1'b0;
    check("t2_run", 64'(bus.ch_running[1]), 64'd1);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.ch_timeout[1]) begin
        found = 1'b1;
        break;
      end
    end
    check("t2_first", 64'(found), 64'd1);
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 11; c++) begin
        step();
        check("t2_gap", 64'(bus.ch_timeout[1]), 64'd0);
      end
      step();
      check("t2_pulse", 64'(bus.ch_timeout[1]), 64'd1);
      check("t2_stay",  64'(bus.ch_running[1]), 64'd1);
    end
    bus.ch_stop[1] = 1'b1;
    step();
    bus.ch_stop[1] = 1'b0;
    bus.ch_periodic[1] = 1'b0;
    check("t2_stop_run", 64'(bus.ch_running[1]), 64'd0);
    check("t2_stop_cnt", 64'(cnt(1)), 64'd0);
    bus.prescale = 8'd0;

    // 3) stop+start together, then restart mid-run
    bus.ch_reload[2*W +: W] = 16'd10;
    bus.ch_start[2] = 1'b1;
    step();
    bus.ch_start[2] = 1'b0;
    check("t3_cnt10", 64'(cnt(2)), 64'd10);
    repeat (7) step();
    check("t3_cnt3", 64'(cnt(2)), 64'd3);
    bus.ch_stop[2]  = 1'b1;
    bus.ch_start[2] = 1'b1;
    step();
    bus.ch_stop[2]  = 1'b0;
    bus.ch_start[2] = 1'b0;
    check("t3_ss_run", 64'(bus.ch_running[2]), 64'd0);
    check("t3_ss_cnt", 64'(cnt(2)), 64'd0);
    check("t3_ss_tmo", 64'(bus.ch_timeout[2]), 64'd0);
    bus.ch_start[2] = 1'b1;
    step();
    bus.ch_start[2] = 1'b0;
    repeat (7) step();
    check("t3_cnt3b", 64'(cnt(2)), 64'd3);
    bus.ch_start[2] = 1'b1;
    step();
    bus.ch_start[2] = 1'b0;
    check("t3_re_cnt", 64'(cnt(2)), 64'd10);
    check("t3_re_tmo", 64'(bus.ch_timeout[2]), 64'd0);
    check("t3_re_run", 64'(bus.ch_running[2]), 64'd1);
    bus.ch_stop[2] = 1'b1;
    step();
    bus.ch_stop[2] = 1'b0;
    check("t3_flag", 64'(bus.irq_flags[2]), 64'd0);

    // 4) reload 0: one-shot then periodic
    bus.ch_reload[3*W +: W] = 16'd0;
    bus.ch_start[3] = 1'b1;
    step();
    bus.ch_start[3] = 1'b0;
    check("t4_os_run", 64'(bus.ch_running[3]), 64'd1);
    check("t4_os_tmo0", 64'(bus.ch_timeout[3]), 64'd0);
    step();
    check("t4_os_tmo", 64'(bus.ch_timeout[3]), 64'd1);
    check("t4_os_idle", 64'(bus.ch_running[3]), 64'd0);
    step();
    check("t4_os_tmo_end", 64'(bus.ch_timeout[3]), 64'd0);
    bus.ch_periodic[3] = 1'b1;
    bus.ch_start[3] = 1'b1;
    step();
    bus.ch_start[3] = 1'b0;
    check("t4_p_tmo0", 64'(bus.ch_timeout[3]), 64'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t4_p_tmo", 64'(bus.ch_timeout[3]), 64'd1);
    end
    bus.ch_stop[3] = 1'b1;
    step();
    bus.ch_stop[3] = 1'b0;
    bus.ch_periodic[3] = 1'b0;
    check("t4_stop_tmo", 64'(bus.ch_timeout[3]), 64'd0);
    check("t4_stop_run", 64'(bus.ch_running[3]), 64'd0);

    // 5) set beats clear in the same cycle
    bus.irq_clear = '1;
    step();
    bus.irq_clear = '0;
    check("t5_allclr", 64'(bus.irq), 64'd0);
    bus.ch_reload[0*W +: W] = 16'd2;
    bus.ch_start[0] = 1'b1;
    step();
    bus.ch_start[0] = 1'b0;
    check("t5_cnt2", 64'(cnt(0)), 64'd2);
    step();
    step();
    check("t5_cnt0", 64'(cnt(0)), 64'd0);
    bus.irq_clear[0] = 1'b1;
    step();
    check("t5_tmo",  64'(bus.ch_timeout[0]), 64'd1);
    check("t5_keep", 64'(bus.irq_flags[0]), 64'd1);
    step();
    bus.irq_clear[0] = 1'b0;
    check("t5_clr",  64'(bus.irq_flags), 64'h0);
    check("t5_irq0", 64'(bus.irq), 64'd0);

    // 6) all channels, then reset mid-run
    bus.ch_reload = {16'd4, 16'd3, 16'd2, 16'd1};
    bus.ch_start  = 4'hf;
    step();
    bus.ch_start  = 4'h0;
    check("t6_cnt_a", 64'(bus.ch_count), {16'd4, 16'd3, 16'd2, 16'd1});
    check("t6_run",   64'(bus.ch_running), 64'hf);
    step();
    check("t6_cnt_b", 64'(bus.ch_count), {16'd3, 16'd2, 16'd1, 16'd0});
    resetb = 1'b0;
    step();
    check("t6_rst_run",  64'(bus.ch_running), 64'h0);
    check("t6_rst_cnt",  64'(bus.ch_count),   64'h0);
    check("t6_rst_tmo",  64'(bus.ch_timeout), 64'h0);
    check("t6_rst_flag", 64'(bus.irq_flags),  64'h0);
    check("t6_rst_irq",  64'(bus.irq),        64'h0);
    resetb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_post_tmo", 64'(bus.ch_timeout), 64'h0);
      check("t6_post_run", 64'(bus.ch_running), 64'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
